// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding and the data/requester sizing constants.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester with its bit set,
// scanning from ptr upward and wrapping at N-1 -> 0.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Distance of each requester from ptr; the smallest distance among active requests wins.
  logic [ID_W:0] best_off;
  logic [ID_W:0] off;

  always_comb begin
    idx      = '0;
    any      = 1'b0;
    best_off = '1;
    off      = '0;
    for (int j = 0; j < N; j++) begin
      if (ID_W'(j) >= ptr) begin
        off = {1'b0, ID_W'(j) - ptr};
      end else begin
        off = (ID_W + 1)'(j + N) - {1'b0, ptr};
      end
      if (req[j] && (off < best_off)) begin
        best_off = off;
        idx      = ID_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between NUM_REQ valid/ready byte streams, granting
// round-robin per packet and releasing on the last byte's tx_done or on a mid-packet gap timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GAP_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic                           grant_vld,
  output logic [2:0]                     grant_id,
  output logic                           gap_err
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT) + 1;

  arb_state_t             state_reg, state_next;
  logic [ID_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic                   grant_vld_reg, grant_vld_next;
  logic [ID_W-1:0]        grant_id_reg, grant_id_next;
  logic [UART_DATA_W-1:0] tx_data_reg, tx_data_next;
  logic                   last_reg, last_next;
  logic                   tx_start_reg, tx_start_next;
  logic                   gap_err_reg, gap_err_next;
  logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;

  logic                   sel_valid;
  logic                   sel_last;
  logic [UART_DATA_W-1:0] sel_data;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic [ID_W-1:0]        ptr_after;
  logic                   accept;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the granted stream is looked at; everyone else is ignored while a grant is held.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_reg == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[UART_DATA_W*i +: UART_DATA_W];
      end
    end
  end

  assign accept    = (state_reg == ST_SEND) && sel_valid && !tx_busy;
  assign ptr_after = (grant_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_id_reg == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_vld_next = grant_vld_reg;
    grant_id_next  = grant_id_reg;
    tx_data_next   = tx_data_reg;
    last_next      = last_reg;
    tx_start_next  = 1'b0;
    gap_err_next   = 1'b0;
    gap_cnt_next   = gap_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        gap_cnt_next = '0;
        if (pick_any) begin
          grant_id_next  = pick_idx;
          grant_vld_next = 1'b1;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_data_next  = sel_data;
          last_next     = sel_last;
          tx_start_next = 1'b1;
          gap_cnt_next  = '0;
          state_next    = ST_WAIT;
        end else if (!sel_valid) begin
          if (gap_cnt_reg == GAP_W'(GAP_TIMEOUT - 1)) begin
            gap_err_next   = 1'b1;
            grant_vld_next = 1'b0;
            rr_ptr_next    = ptr_after;
            gap_cnt_next   = '0;
            state_next     = ST_IDLE;
          end else if (gap_cnt_reg != {GAP_W{1'b1}}) begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A done coincident with our own start pulse belongs to no byte of ours.
        if (tx_done && !tx_start_reg) begin
          if (last_reg) begin
            grant_vld_next = 1'b0;
            rr_ptr_next    = ptr_after;
            state_next     = ST_IDLE;
          end else begin
            state_next = ST_SEND;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      grant_vld_reg <= 1'b0;
      grant_id_reg  <= '0;
      tx_data_reg   <= '0;
      last_reg      <= 1'b0;
      tx_start_reg  <= 1'b0;
      gap_err_reg   <= 1'b0;
      gap_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_vld_reg <= grant_vld_next;
      grant_id_reg  <= grant_id_next;
      tx_data_reg   <= tx_data_next;
      last_reg      <= last_next;
      tx_start_reg  <= tx_start_next;
      gap_err_reg   <= gap_err_next;
      gap_cnt_reg   <= gap_cnt_next;
    end
  end

  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;
  assign grant_vld = grant_vld_reg;
  assign grant_id  = grant_id_reg;
  assign gap_err   = gap_err_reg;

endmodule
